// File: rtl/xintf_arbiter.sv
// xintf_arbiter: two-requester round-robin arbiter driving an XINTF-style
// external bus (zone 6 / zone 7 chip selects, separate read/write strobes).
//
// Parameters:
//   SETUP_CYC   (1..15)  address/zone setup cycles before the strobe
//   STROBE_CYC  (1..15)  minimum strobe-low cycles
//   HOLD_CYC    (1..15)  address/data hold cycles after strobe release
//   TIMEOUT_CYC (1..255) xready wait limit (only with XINTF_ARB_TIMEOUT_EN)
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   req_valid/we/zone [1:0]    per-requester request, direction, zone (0=6, 1=7)
//   req_addr/req_wdata [31:0]  packed per-requester address / write data
//   req_accept/req_done [1:0]  one-cycle capture / completion pulses
//   rdata [15:0], timeout      read data and abort flag, valid with req_done
//   xready                     external ready, low stretches the strobe
//   xwen, xrdn                 active-low write / read strobes
//   zone_6_n, zone_7_n         active-low chip selects
//   xa [15:0], xd [15:0]       external address and bidirectional data
//
// Optional feature macro: XINTF_ARB_TIMEOUT_EN bounds the xready wait to
// TIMEOUT_CYC cycles; without it the wait is unbounded and timeout stays 0.

module xintf_arbiter #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_we,
  input  logic [1:0]  req_zone,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [1:0]  req_accept,
  output logic [1:0]  req_done,
  output logic [15:0] rdata,
  output logic        timeout,
  input  logic        xready,
  output logic        xwen,
  output logic        xrdn,
  output logic        zone_6_n,
  output logic        zone_7_n,
  output logic [15:0] xa,
  inout  wire  [15:0] xd
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 16;

  // Elaboration-time guard on the legal parameter ranges.
  if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
      HOLD_CYC < 1 || HOLD_CYC > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_param
    $error("xintf_arbiter: timing parameter out of legal range");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    WAIT   = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                ptr;        // requester favoured at the next grant
  logic                sel_q;      // requester owning the current transaction
  logic                we_q, zone_q, to_q, xd_oe;
  logic [DATA_W-1:0]   wdata_q;

  logic                grant, gnt_id, capture, to_hit, done_nxt;
  logic                we_nxt, zone_nxt, active_nxt, strobe_nxt;
  logic [DATA_W-1:0]   addr_sel, wdata_sel;

  // Data bus is only driven while a write owns the bus.
  assign xd = xd_oe ? wdata_q : {DATA_W{1'bz}};

  // Next-state, grant and phase-counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    grant     = 1'b0;
    gnt_id    = req_valid[ptr] ? ptr : ~ptr;
    capture   = 1'b0;
    to_hit    = 1'b0;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        // The done-pulse cycle is forced idle so transactions never abut.
        if ((|req_valid) && !(|req_done)) begin
          grant     = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (cnt == CNT_W'(SETUP_CYC - 1)) begin
          state_nxt = STROBE;
          cnt_nxt   = '0;
        end
      end
      STROBE: begin
        if (cnt == CNT_W'(STROBE_CYC - 1)) begin
          cnt_nxt = '0;
          if (xready) begin
            state_nxt = HOLD;
            capture   = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (xready) begin
          state_nxt = HOLD;
          capture   = 1'b1;
          cnt_nxt   = '0;
        end
`ifdef XINTF_ARB_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_nxt = HOLD;
          to_hit    = 1'b1;
          cnt_nxt   = '0;
        end
`else
        else begin
          cnt_nxt = '0;
        end
`endif
      end
      HOLD: begin
        if (cnt == CNT_W'(HOLD_CYC - 1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Bus outputs are registered from next-state so they line up with state.
    we_nxt     = grant ? req_we[gnt_id]   : we_q;
    zone_nxt   = grant ? req_zone[gnt_id] : zone_q;
    active_nxt = (state_nxt != IDLE);
    strobe_nxt = (state_nxt == STROBE) || (state_nxt == WAIT);
    addr_sel   = gnt_id ? req_addr[31:16]  : req_addr[15:0];
    wdata_sel  = gnt_id ? req_wdata[31:16] : req_wdata[15:0];
  end

  // State, captured request and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= 1'b0;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      zone_q     <= 1'b0;
      to_q       <= 1'b0;
      xd_oe      <= 1'b0;
      wdata_q    <= '0;
      req_accept <= '0;
      req_done   <= '0;
      timeout    <= 1'b0;
      rdata      <= '0;
      xwen       <= 1'b1;
      xrdn       <= 1'b1;
      zone_6_n   <= 1'b1;
      zone_7_n   <= 1'b1;
      xa         <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      req_accept <= grant    ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
      req_done   <= done_nxt ? (sel_q  ? 2'b10 : 2'b01) : 2'b00;
      timeout    <= done_nxt & to_q;
      we_q       <= we_nxt;
      zone_q     <= zone_nxt;
      if (grant) begin
        xa      <= addr_sel;
        wdata_q <= wdata_sel;
        sel_q   <= gnt_id;
        ptr     <= ~gnt_id;   // just-served requester drops to lowest priority
        to_q    <= 1'b0;
      end
      if (to_hit) begin
        to_q <= 1'b1;
      end
      if (capture && !we_q) begin
        rdata <= xd;
      end
      zone_6_n <= ~(active_nxt & ~zone_nxt);
      zone_7_n <= ~(active_nxt &  zone_nxt);
      xwen     <= ~(strobe_nxt &  we_nxt);
      xrdn     <= ~(strobe_nxt & ~we_nxt);
      xd_oe    <= active_nxt & we_nxt;
    end
  end

endmodule

// File: tb/tb_xintf_arbiter.sv
// Self-checking bench for xintf_arbiter: vector table, directed corner
// sequences and randomized transactions against a transaction-level model.

module tb_xintf_arbiter;

  localparam int S = 2;
  localparam int P = 4;
  localparam int H = 1;
  localparam int T = 8;
`ifdef XINTF_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_we, req_zone;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_accept, req_done;
  logic [15:0] rdata;
  logic        timeout, xready, xwen, xrdn, zone_6_n, zone_7_n;
  logic [15:0] xa;
  wire  [15:0] xd;
  logic [15:0] tb_xd;

  always #5 clk = ~clk;

  // External device answers reads while the read strobe is low.
  assign xd = (!xrdn) ? tb_xd : 16'hzzzz;

  xintf_arbiter #(
    .SETUP_CYC(S), .STROBE_CYC(P), .HOLD_CYC(H), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_zone(req_zone),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_accept(req_accept), .req_done(req_done),
    .rdata(rdata), .timeout(timeout), .xready(xready),
    .xwen(xwen), .xrdn(xrdn), .zone_6_n(zone_6_n), .zone_7_n(zone_7_n),
    .xa(xa), .xd(xd)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Observations of the last transaction.
  logic [1:0]  obs_acc, obs_done;
  logic [15:0] obs_rd;
  logic        obs_to, obs_xd_bad, obs_xa_bad, obs_excl_bad;
  int          obs_lat, obs_sl, obs_z6, obs_z7, obs_wait;

  // Transaction-level reference: favoured requester and last read value.
  int          m_fav   = 0;
  logic [15:0] m_rdata = '0;

  logic [1:0]  e_acc;
  int          e_lat, e_sl, e_z6, e_z7;
  logic [15:0] e_rd;
  logic        e_to;

  task automatic model_exp(input logic [1:0] mask, we, zone, input logic [15:0] rdv, input int w);
    int g, weff;
    g     = mask[m_fav] ? m_fav : 1 - m_fav;
    e_acc = (g == 1) ? 2'b10 : 2'b01;
    e_to  = TO_EN && (w > T);
    weff  = e_to ? T : w;
    e_lat = S + P + H + weff;
    e_sl  = P + weff;
    e_z6  = zone[g] ? 0 : e_lat;
    e_z7  = zone[g] ? e_lat : 0;
    if (!we[g] && !e_to) m_rdata = rdv;
    e_rd  = m_rdata;
    m_fav = 1 - g;
  endtask

  // Issue a request, stall xready for w WAIT cycles, observe until done.
  task automatic run_txn(input logic [1:0] mask, we, zone, input logic [31:0] addr, wdata,
                         input logic [15:0] rdv, input int w);
    logic sel, ewe, zl;
    logic [15:0] ea, ed;
    req_valid = mask; req_we = we; req_zone = zone;
    req_addr = addr; req_wdata = wdata; tb_xd = rdv; xready = 1'b0;
    obs_acc = '0; obs_done = '0; obs_to = 1'b0; obs_rd = rdata;
    obs_lat = 0; obs_sl = 0; obs_z6 = 0; obs_z7 = 0; obs_wait = 0;
    obs_xd_bad = 1'b0; obs_xa_bad = 1'b0; obs_excl_bad = 1'b0;
    do begin
      @(negedge clk);
      obs_wait++;
    end while (req_accept == 2'b00 && obs_wait < 40);
    obs_acc = req_accept;
    if (obs_acc != 2'b00) begin
      sel = obs_acc[1];
      ea  = sel ? addr[31:16]  : addr[15:0];
      ed  = sel ? wdata[31:16] : wdata[15:0];
      ewe = we[sel];
      req_valid = mask & ~obs_acc;
      for (int i = 0; i < 300; i++) begin
        if (i > 0) begin
          @(negedge clk);
          obs_lat++;
        end
        zl = !zone_6_n || !zone_7_n;
        if (!xwen || !xrdn) obs_sl++;
        if (!zone_6_n) obs_z6++;
        if (!zone_7_n) obs_z7++;
        if ((!zone_6_n && !zone_7_n) || (!xwen && !xrdn)) obs_excl_bad = 1'b1;
        if ((ewe && !xrdn) || (!ewe && !xwen)) obs_excl_bad = 1'b1;
        if (zl && xa !== ea) obs_xa_bad = 1'b1;
        if (zl && ewe && xd !== ed) obs_xd_bad = 1'b1;
        xready = (obs_sl >= P + w);
        if (req_done != 2'b00) begin
          obs_done = req_done;
          obs_rd   = rdata;
          obs_to   = timeout;
          break;
        end
      end
    end
    xready = 1'b1;
    req_valid = 2'b00;
  endtask

  task automatic vfy(input string tag, input logic [1:0] eacc, input int elat, esl, ez6, ez7,
                     input logic [15:0] erd, input logic eto);
    check($sformatf("%s_accept", tag), 32'(obs_acc), 32'(eacc));
    check($sformatf("%s_done", tag), 32'(obs_done), 32'(eacc));
    check($sformatf("%s_latency", tag), obs_lat, elat);
    check($sformatf("%s_strobe_cyc", tag), obs_sl, esl);
    check($sformatf("%s_zone6_cyc", tag), obs_z6, ez6);
    check($sformatf("%s_zone7_cyc", tag), obs_z7, ez7);
    check($sformatf("%s_rdata", tag), 32'(obs_rd), 32'(erd));
    check($sformatf("%s_timeout", tag), 32'(obs_to), 32'(eto));
    check($sformatf("%s_xa", tag), 32'(obs_xa_bad), 32'd0);
    check($sformatf("%s_xd", tag), 32'(obs_xd_bad), 32'd0);
    check($sformatf("%s_excl", tag), 32'(obs_excl_bad), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  mask, we, zone;
    logic [31:0] addr, wdata;
    logic [15:0] rdv;
    int          w;
    logic [1:0]  eacc;
    int          elat, esl, ez6, ez7;
    logic [15:0] erd;
    logic        eto;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rm, rw, rz;
    logic [31:0] ra, rd;
    logic [15:0] rv;
    int rwt, dones;

    // Table: directed single-requester transactions with hand-derived results.
    tbl[0] = '{2'b01, 2'b01, 2'b00, 32'h0000_0040, 32'h0000_BEEF, 16'h0000, 0,
               2'b01, 7, 4, 7, 0, 16'h0000, 1'b0};
    tbl[1] = '{2'b10, 2'b00, 2'b10, 32'h0123_0000, 32'h0000_0000, 16'h1234, 0,
               2'b10, 7, 4, 0, 7, 16'h1234, 1'b0};
    tbl[2] = '{2'b01, 2'b01, 2'b01, 32'h0000_7FFF, 32'h0000_A5A5, 16'h0000, 3,
               2'b01, 10, 7, 0, 10, 16'h1234, 1'b0};
    tbl[3] = '{2'b10, 2'b00, 2'b00, 32'hFFFF_0000, 32'h0000_0000, 16'hC3C3, 1,
               2'b10, 8, 5, 8, 0, 16'hC3C3, 1'b0};
    tbl[4] = '{2'b01, 2'b00, 2'b00, 32'h0000_0002, 32'h0000_0000, 16'h0F0F, 2,
               2'b01, 9, 6, 9, 0, 16'h0F0F, 1'b0};

    reset = 1'b1; req_valid = '0; req_we = '0; req_zone = '0;
    req_addr = '0; req_wdata = '0; xready = 1'b1; tb_xd = '0;
    repeat (3) @(negedge clk);
    check("rst_xwen", 32'(xwen), 32'd1);
    check("rst_xrdn", 32'(xrdn), 32'd1);
    check("rst_zones", 32'({zone_6_n, zone_7_n}), 32'h3);
    check("rst_xa", 32'(xa), 32'd0);
    check("rst_pulses", 32'({req_accept, req_done, timeout}), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    reset = 1'b0;

    // Contention: both requesters always pending, grants alternate from 0.
    for (int i = 0; i < 4; i++) begin
      model_exp(2'b11, 2'b11, 2'b10, 16'h0, 0);
      run_txn(2'b11, 2'b11, 2'b10, 32'h0200_0100, 32'h2222_1111, 16'h0, 0);
      check($sformatf("rr_order%0d", i), 32'(obs_acc), (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i > 0) check($sformatf("rr_gap%0d", i), obs_wait, 2);
      vfy($sformatf("rr%0d", i), e_acc, e_lat, e_sl, e_z6, e_z7, e_rd, e_to);
    end

    for (int i = 0; i < 5; i++) begin
      model_exp(tbl[i].mask, tbl[i].we, tbl[i].zone, tbl[i].rdv, tbl[i].w);
      run_txn(tbl[i].mask, tbl[i].we, tbl[i].zone, tbl[i].addr, tbl[i].wdata, tbl[i].rdv, tbl[i].w);
      vfy($sformatf("vec%0d", i), tbl[i].eacc, tbl[i].elat, tbl[i].esl, tbl[i].ez6, tbl[i].ez7,
          tbl[i].erd, tbl[i].eto);
    end

    // Stretch: ten WAIT cycles on a read.
    model_exp(2'b01, 2'b00, 2'b01, 16'h5A5A, 10);
    run_txn(2'b01, 2'b00, 2'b01, 32'h0000_0300, 32'h0, 16'h5A5A, 10);
    check("stretch_latency", obs_lat, TO_EN ? 15 : 17);
    check("stretch_strobe", obs_sl, TO_EN ? 12 : 14);
    vfy("stretch", e_acc, e_lat, e_sl, e_z6, e_z7, e_rd, e_to);

    // Stuck xready: aborted by timeout when enabled, else a long stretch.
    model_exp(2'b10, 2'b00, 2'b00, 16'h7777, 100);
    run_txn(2'b10, 2'b00, 2'b00, 32'h0400_0000, 32'h0, 16'h7777, 100);
    check("stuck_timeout", 32'(obs_to), 32'(TO_EN));
    check("stuck_latency", obs_lat, TO_EN ? 15 : 107);
    vfy("stuck", e_acc, e_lat, e_sl, e_z6, e_z7, e_rd, e_to);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 20; i++) begin
      rm  = 2'($urandom_range(1, 3));
      rw  = 2'($urandom_range(0, 3));
      rz  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rd  = $urandom;
      rv  = 16'($urandom);
      rwt = $urandom_range(0, 5);
      model_exp(rm, rw, rz, rv, rwt);
      run_txn(rm, rw, rz, ra, rd, rv, rwt);
      check($sformatf("rnd%0d_gap", i), obs_wait, 2);
      vfy($sformatf("rnd%0d", i), e_acc, e_lat, e_sl, e_z6, e_z7, e_rd, e_to);
    end

    // Reset during STROBE of a requester-0 write aborts it silently.
    req_valid = 2'b01; req_we = 2'b01; req_zone = 2'b00;
    req_addr = 32'h0000_0555; req_wdata = 32'h0000_9999; xready = 1'b0;
    rwt = 0;
    do begin
      @(negedge clk);
      rwt++;
      if (req_accept != 2'b00) req_valid = 2'b00;
    end while (xwen && rwt < 40);
    check("abort_reached_strobe", 32'(xwen), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_strobes", 32'({xwen, xrdn}), 32'h3);
    check("abort_zones", 32'({zone_6_n, zone_7_n}), 32'h3);
    check("abort_xa", 32'(xa), 32'd0);
    check("abort_rdata", 32'(rdata), 32'd0);
    reset = 1'b0; xready = 1'b1;
    m_fav = 0; m_rdata = '0;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (req_done != 2'b00) dones++;
    end
    check("abort_no_done", dones, 0);
    model_exp(2'b11, 2'b01, 2'b10, 16'h0, 0);
    run_txn(2'b11, 2'b01, 2'b10, 32'h0002_0001, 32'h0004_0003, 16'h0, 0);
    check("abort_next_grant", 32'(obs_acc), 32'h1);
    vfy("post_abort", e_acc, e_lat, e_sl, e_z6, e_z7, e_rd, e_to);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/xintf_arbiter.md
XINTF_ARBITER -- requirements
Module: xintf_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- SETUP_CYC, 2, cycles of address/zone setup before strobe (legal 1..15).
- STROBE_CYC, 4, minimum cycles xwen/xrdn held low (legal 1..15).
- HOLD_CYC, 1, cycles of address/data hold after strobe release (legal 1..15).
- TIMEOUT_CYC, 255, maximum xready-wait cycles (legal 1..255).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- reset, in, 1, synchronous, active-high reset.
- req_valid, in, 2, per-requester transaction request; bit n belongs to requester n.
- req_we, in, 2, per-requester direction: 1=write, 0=read.
- req_zone, in, 2, per-requester zone select: 0=zone 6, 1=zone 7.
- req_addr, in, 32, packed addresses; requester n uses [16n+15:16n].
- req_wdata, in, 32, packed write data; same packing as req_addr.
- req_accept, out, 2, one-cycle pulse when a request is captured.
- req_done, out, 2, one-cycle pulse when the granted transaction completes.
- rdata, out, 16, read data, valid on the cycle req_done pulses.
- timeout, out, 1, qualifies req_done: the transaction was aborted.
- xready, in, 1, external ready; low stretches the strobe.
- xwen, out, 1, active-low write strobe.
- xrdn, out, 1, active-low read strobe.
- zone_6_n, out, 1, active-low zone 6 chip select.
- zone_7_n, out, 1, active-low zone 7 chip select.
- xa, out, 16, external address.
- xd, inout, 16, external data, driven only during write SETUP/STROBE/WAIT/HOLD, else high-Z.

Function
REQ-003 The FSM SHALL have states IDLE, SETUP, STROBE, WAIT and HOLD.
REQ-004 IDLE arbitration:
- If any req_valid bit is set, the block grants one requester round-robin.
- A requester that was just served has lowest priority.
- The pointer resets to favour requester 0.
REQ-005 On grant, in the same cycle the block SHALL:
- pulse req_accept[n];
- register addr, wdata, we and zone;
- enter SETUP.
Requester inputs are don't-care after accept.
REQ-006 SETUP:
- asserts the selected zone_n and drives xa (and xd on writes);
- strobes stay high;
- lasts exactly SETUP_CYC cycles, then enters STROBE.
REQ-007 STROBE:
- drives xwen (write) or xrdn (read) low;
- lasts STROBE_CYC cycles;
- on its last cycle, goes to HOLD if xready=1, else to WAIT.
REQ-008 WAIT:
- keeps the strobe low;
- goes to HOLD on the first cycle xready=1.
REQ-009 Read data SHALL be captured from xd on the cycle the FSM leaves STROBE/WAIT with xready=1.
REQ-010 HOLD:
- strobes high, zone and xa (and xd on writes) unchanged;
- lasts HOLD_CYC cycles;
- on its last cycle, the block pulses req_done[n] and returns to IDLE.
REQ-011 A new grant SHALL NOT occur in the cycle req_done pulses, so there is at least one IDLE cycle between transactions.
REQ-012 Accept-to-done latency SHALL be SETUP_CYC+STROBE_CYC+HOLD_CYC+W cycles, where W is the number of WAIT cycles.
REQ-013 At most one zone_n SHALL be low at any time, and xwen and xrdn SHALL never both be low.
REQ-014 A requester SHALL NOT see its req_done before its own req_accept.
REQ-015 rdata SHALL hold its value until the next read completes; writes leave it unchanged.

Reset
REQ-016 While reset=1, at the next clk edge the block SHALL:
- enter IDLE;
- drive xwen, xrdn, zone_6_n and zone_7_n = 1, xa = 0, xd high-Z;
- clear req_accept, req_done, timeout and rdata to 0;
- set the round-robin pointer to favour requester 0.
REQ-017 A reset mid-transaction SHALL abort the transaction with no req_done pulse.

Configuration
REQ-018 With XINTF_ARB_TIMEOUT_EN defined, WAIT SHALL count cycles, and after TIMEOUT_CYC cycles with xready=0 it SHALL:
- go to HOLD;
- at done, pulse req_done with timeout=1;
- leave rdata unchanged.
REQ-019 Without XINTF_ARB_TIMEOUT_EN, WAIT SHALL be unbounded, and timeout SHALL be tied to 0.

Verification
REQ-020 Single write: requester 0 writes addr 0x0040, data 0xBEEF, zone 6, xready=1 -> accept, then:
- zone_6_n low 7 cycles, xwen low 4 cycles, xd=0xBEEF throughout;
- req_done[0] 7 cycles after accept.
REQ-021 Read: requester 1, zone 7, xd=0x1234, xready=1 -> xrdn low 4 cycles, rdata=0x1234 with req_done[1].
REQ-022 Contention: both req_valid held high for 4 transactions -> grants alternate 0,1,0,1.
REQ-023 Stretch: xready held low for 10 cycles after STROBE -> xrdn low 14 cycles, latency 17.
REQ-024 Timeout: macro defined, TIMEOUT_CYC=8, xready stuck low -> req_done with timeout=1 after 8 WAIT cycles.
REQ-025 Reset pulse during STROBE -> strobes and zones high next cycle, no req_done pulse, next grant to requester 0.
